// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with leading-zero blanking and decimal points.
// Inputs are captured once per frame so the display never shows a half-updated value.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [15:0]   r_shadow_digits;
  logic [3:0]    r_shadow_dp;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  logic          w_tick;
  logic          w_frame_start;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_seg_on;
  logic [3:0]    w_an_on;
  logic          w_dp_on;

  assign w_tick        = (r_cnt == CNT_LAST);
  assign w_frame_start = (r_sel == 2'd0) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_sel <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
    end else if (w_frame_start) begin
      r_shadow_digits <= digits;
      r_shadow_dp     <= dp_mask;
    end
  end

  // A slot is blanked only when it and every more significant digit are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_sel)
      2'd1:    w_blank = blank_lz && (r_shadow_digits[15:4]  == 12'd0);
      2'd2:    w_blank = blank_lz && (r_shadow_digits[15:8]  == 8'd0);
      2'd3:    w_blank = blank_lz && (r_shadow_digits[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end

  assign w_digit = r_shadow_digits[{r_sel, 2'b00} +: 4];

  // Active-high pattern {g,f,e,d,c,b,a}; non-BCD values show a dash.
  always_comb begin
    w_seg_on = 7'b1000000;
    case (w_digit)
      4'd0:    w_seg_on = 7'b0111111;
      4'd1:    w_seg_on = 7'b0000110;
      4'd2:    w_seg_on = 7'b1011011;
      4'd3:    w_seg_on = 7'b1001111;
      4'd4:    w_seg_on = 7'b1100110;
      4'd5:    w_seg_on = 7'b1101101;
      4'd6:    w_seg_on = 7'b1111101;
      4'd7:    w_seg_on = 7'b0000111;
      4'd8:    w_seg_on = 7'b1111111;
      4'd9:    w_seg_on = 7'b1101111;
      default: w_seg_on = 7'b1000000;
    endcase
  end

  assign w_an_on = w_blank ? 4'b0000 : (4'b0001 << r_sel);
  assign w_dp_on = !w_blank && r_shadow_dp[r_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= {7{ACTIVE_LOW}};
      r_dp  <= ACTIVE_LOW;
      r_an  <= {4{ACTIVE_LOW}};
    end else begin
      r_seg <= (w_blank ? 7'b0000000 : w_seg_on) ^ {7{ACTIVE_LOW}};
      r_dp  <= w_dp_on ^ ACTIVE_LOW;
      r_an  <= w_an_on ^ {4{ACTIVE_LOW}};
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-indexed reference model predicts each
// registered output word; a monitor compares one word per clock.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];

  // Model state: cycles since reset and the digits latched at the current frame start.
  int          m_n = 0;
  logic [15:0] m_cap_dig = 16'h0000;
  logic [3:0]  m_cap_dp = 4'h0;
  logic [6:0]  lit_tab [0:15];

  seg7_scan_driver #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .digits   (digits),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  initial begin
    lit_tab[0] = 7'b0111111; lit_tab[1] = 7'b0000110; lit_tab[2] = 7'b1011011;
    lit_tab[3] = 7'b1001111; lit_tab[4] = 7'b1100110; lit_tab[5] = 7'b1101101;
    lit_tab[6] = 7'b1111101; lit_tab[7] = 7'b0000111; lit_tab[8] = 7'b1111111;
    lit_tab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) lit_tab[i] = 7'b1000000;
  end

  // Predicts the output word produced by the coming rising edge from the inputs now applied.
  task automatic model_push();
    obs_t e;
    int   sel;
    logic [15:0] upper;
    logic [3:0]  dval;
    logic        blank;
    if (reset) begin
      e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
      m_n = 0;
      m_cap_dig = 16'h0000;
      m_cap_dp = 4'h0;
    end else begin
      sel   = (m_n / DIV) % 4;
      upper = m_cap_dig >> (4 * sel);
      dval  = upper[3:0];
      blank = blank_lz && (sel != 0) && (upper == 16'h0000);
      if (blank) begin
        e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
      end else begin
        e.an  = ~(4'b0001 << sel);
        e.seg = ~lit_tab[dval];
        e.dp  = ~m_cap_dp[sel];
      end
      if (m_n % FRAME == 0) begin
        m_cap_dig = digits;
        m_cap_dp  = dp_mask;
      end
      m_n++;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [15:0] dg, input logic [3:0] dm, input logic bl);
    @(negedge clk);
    reset    = rst;
    digits   = dg;
    dp_mask  = dm;
    blank_lz = bl;
    model_push();
  endtask

  task automatic run(input int n, input logic [15:0] dg, input logic [3:0] dm, input logic bl);
    for (int i = 0; i < n; i++) step(1'b0, dg, dm, bl);
  endtask

  always @(posedge clk) begin
    obs_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL scan_out t=%0t got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  initial begin
    logic [15:0] dg;
    logic [3:0]  dm;
    logic        bl;
    logic [15:0] masks [0:4];
    masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
    masks[3] = 16'h000F; masks[4] = 16'h0000;

    for (int i = 0; i < 3; i++) step(1'b1, 16'h1234, 4'h0, 1'b0);
    run(2 * FRAME, 16'h1234, 4'h0, 1'b0);
    run(2 * FRAME, 16'h0050, 4'h0, 1'b1);
    run(FRAME, 16'h0050, 4'h0, 1'b0);
    run(6, 16'h1234, 4'h0, 1'b0);
    run(FRAME + 10, 16'h5678, 4'h0, 1'b0);
    run(2 * FRAME, 16'hA000, 4'b0100, 1'b1);
    run(10, 16'h1234, 4'h3, 1'b0);
    step(1'b1, 16'h1234, 4'h3, 1'b0);
    run(2 * FRAME, 16'h9876, 4'h8, 1'b1);

    dg = 16'h0000; dm = 4'h0; bl = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) dg = 16'($urandom) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) dm = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bl = ~bl;
      step($urandom_range(0, 99) == 0, dg, dm, bl);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
